// File: rtl/accel_spi_pkg.sv
// rtl/accel_spi_pkg.sv - shared state type, command codes and register map for the accel SPI responder
package accel_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } spi_state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
  localparam logic [7:0] ADDR_PARTID     = 8'h02;
  localparam logic [7:0] ADDR_XDATA      = 8'h08;
  localparam logic [7:0] ADDR_YDATA      = 8'h09;
  localparam logic [7:0] ADDR_ZDATA      = 8'h0A;
  localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
  localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
  localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

  localparam logic [7:0] ID_DEVID_AD  = 8'hAD;
  localparam logic [7:0] ID_DEVID_MST = 8'h1D;
  localparam logic [7:0] ID_PARTID    = 8'hF2;

  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  // High byte of a 12-bit sample is the top nibble sign-extended to 8 bits.
  function automatic logic [7:0] high_byte(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  function automatic logic [7:0] reg_read(
    input logic [7:0]  addr,
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [11:0] z,
    input logic [7:0]  pwr
  );
    logic [7:0] v;
    v = 8'h00;
    case (addr)
      ADDR_DEVID_AD:  v = ID_DEVID_AD;
      ADDR_DEVID_MST: v = ID_DEVID_MST;
      ADDR_PARTID:    v = ID_PARTID;
      ADDR_XDATA:     v = x[11:4];
      ADDR_YDATA:     v = y[11:4];
      ADDR_ZDATA:     v = z[11:4];
      ADDR_XDATA_L:   v = x[7:0];
      ADDR_XDATA_H:   v = high_byte(x);
      ADDR_YDATA_L:   v = y[7:0];
      ADDR_YDATA_H:   v = high_byte(y);
      ADDR_ZDATA_L:   v = z[7:0];
      ADDR_ZDATA_H:   v = high_byte(z);
      ADDR_POWER_CTL: v = pwr;
      default:        v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - synchronizes sclk/mosi/ss and flags sclk rise/fall and ss fall/rise
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_ss,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_ss_fall,
  output logic o_ss_rise,
  output logic o_mosi,
  output logic o_ss
);

  logic [SYNC_STAGES-1:0] r_sclk_pipe;
  logic [SYNC_STAGES-1:0] r_mosi_pipe;
  logic [SYNC_STAGES-1:0] r_ss_pipe;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  // ss resets low so a line held low through reset never looks like an idle-high bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_pipe <= '0;
      r_mosi_pipe <= '0;
      r_ss_pipe   <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b0;
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-2:0], i_sclk};
      r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], i_mosi};
      r_ss_pipe   <= {r_ss_pipe[SYNC_STAGES-2:0], i_ss};
      r_sclk_d    <= r_sclk_pipe[SYNC_STAGES-1];
      r_ss_d      <= r_ss_pipe[SYNC_STAGES-1];
    end
  end

  assign o_sclk_rise = r_sclk_pipe[SYNC_STAGES-1] & ~r_sclk_d;
  assign o_sclk_fall = ~r_sclk_pipe[SYNC_STAGES-1] & r_sclk_d;
  assign o_ss_fall   = ~r_ss_pipe[SYNC_STAGES-1] & r_ss_d;
  assign o_ss_rise   = r_ss_pipe[SYNC_STAGES-1] & ~r_ss_d;
  assign o_mosi      = r_mosi_pipe[SYNC_STAGES-1];
  assign o_ss        = r_ss_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/accel_spi_responder.sv
// rtl/accel_spi_responder.sv - SPI mode-0 register responder for a 3-axis accelerometer
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        txn_done
);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_mosi;
  logic w_ss;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk         (clk),
    .reset       (reset),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_ss        (ss),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_ss_fall   (w_ss_fall),
    .o_ss_rise   (w_ss_rise),
    .o_mosi      (w_mosi),
    .o_ss        (w_ss)
  );

  spi_state_t  r_state;
  spi_state_t  w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic [7:0]  r_addr;
  logic        r_is_rd;
  logic        r_is_wr;
  logic        r_byte_seen;
  logic        r_armed;
  logic [11:0] r_hold_x;
  logic [11:0] r_hold_y;
  logic [11:0] r_hold_z;
  logic [11:0] r_snap_x;
  logic [11:0] r_snap_y;
  logic [11:0] r_snap_z;
  logic [7:0]  r_power_ctl;
  logic        r_soft_clr;
  logic        r_txn_done;

  logic        w_start;
  logic        w_active;
  logic        w_byte_done;
  logic [7:0]  w_rx_byte;
  logic [7:0]  w_addr_next;

  // A transaction only starts once ss has been seen high since reset.
  assign w_start     = (r_state == ST_IDLE) && w_ss_fall && r_armed;
  assign w_active    = (r_state != ST_IDLE) && !w_ss_rise;
  assign w_byte_done = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx, w_mosi};
  assign w_addr_next = r_addr + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_CMD;
      ST_CMD: begin
        if (w_ss_rise)        w_state_next = ST_IDLE;
        else if (w_byte_done) w_state_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (w_ss_rise)        w_state_next = ST_IDLE;
        else if (w_byte_done) w_state_next = ST_DATA;
      end
      ST_DATA: if (w_ss_rise) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_addr      <= 8'd0;
      r_is_rd     <= 1'b0;
      r_is_wr     <= 1'b0;
      r_byte_seen <= 1'b0;
      r_armed     <= 1'b0;
      r_hold_x    <= 12'd0;
      r_hold_y    <= 12'd0;
      r_hold_z    <= 12'd0;
      r_snap_x    <= 12'd0;
      r_snap_y    <= 12'd0;
      r_snap_z    <= 12'd0;
      r_power_ctl <= 8'd0;
      r_soft_clr  <= 1'b0;
      r_txn_done  <= 1'b0;
    end else begin
      if (w_ss) r_armed <= 1'b1;

      if (sample_valid) begin
        r_hold_x <= sample_x;
        r_hold_y <= sample_y;
        r_hold_z <= sample_z;
      end

      r_soft_clr <= 1'b0;
      if (r_soft_clr) r_power_ctl <= 8'd0;

      r_txn_done <= w_ss_rise && (r_state != ST_IDLE) && r_byte_seen;

      if (w_start) begin
        r_snap_x    <= r_hold_x;
        r_snap_y    <= r_hold_y;
        r_snap_z    <= r_hold_z;
        r_bit_cnt   <= 3'd0;
        r_rx        <= 7'd0;
        r_tx        <= 8'd0;
        r_is_rd     <= 1'b0;
        r_is_wr     <= 1'b0;
        r_byte_seen <= 1'b0;
      end else if (w_active) begin
        if (w_sclk_rise) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_rx      <= w_rx_byte[6:0];
          if (w_byte_done) begin
            r_byte_seen <= 1'b1;
            case (r_state)
              ST_CMD: begin
                r_is_rd <= (w_rx_byte == CMD_READ);
                r_is_wr <= (w_rx_byte == CMD_WRITE);
              end
              ST_ADDR: begin
                r_addr <= w_rx_byte;
                r_tx   <= reg_read(w_rx_byte, r_snap_x, r_snap_y, r_snap_z, r_power_ctl);
              end
              ST_DATA: begin
                if (r_is_wr) begin
                  if (r_addr == ADDR_POWER_CTL) r_power_ctl <= w_rx_byte;
                  if ((r_addr == ADDR_SOFT_RESET) && (w_rx_byte == SOFT_RESET_KEY)) r_soft_clr <= 1'b1;
                end
                r_addr <= w_addr_next;
                r_tx   <= reg_read(w_addr_next, r_snap_x, r_snap_y, r_snap_z, r_power_ctl);
              end
              default: r_byte_seen <= 1'b1;
            endcase
          end
        end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB on miso.
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign miso      = (r_state == ST_DATA) && r_is_rd && r_tx[7];
  assign power_ctl = r_power_ctl;
  assign txn_done  = r_txn_done;

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb/tb_accel_spi_responder.sv - randomized SPI master against a register-map model of the responder
module tb_accel_spi_responder;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso;
  logic [11:0] sample_x = 12'd0;
  logic [11:0] sample_y = 12'd0;
  logic [11:0] sample_z = 12'd0;
  logic        sample_valid = 1'b0;
  logic [7:0]  power_ctl;
  logic        txn_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit chk_miso_zero = 1'b0;
  bit chk_pwr = 1'b0;
  bit clr_zero_on_last = 1'b0;
  bit mid_en = 1'b0;
  bit end_en = 1'b0;
  logic [11:0] mid_y = 12'd0;
  logic [11:0] end_x = 12'd0;

  int         m_hold[3];
  int         m_snap[3];
  logic [7:0] m_pwr = 8'd0;

  always #5 clk = ~clk;

  accel_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .mosi         (mosi),
    .ss           (ss),
    .miso         (miso),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .txn_done     (txn_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (txn_done) done_cnt++;
      if (chk_miso_zero) check("miso_quiet", {31'd0, miso}, 32'd0);
      if (chk_pwr) check("power_ctl_track", {24'd0, power_ctl}, {24'd0, m_pwr});
    end
  end

  function automatic int to_signed12(input int v);
    return (v >= 2048) ? v - 4096 : v;
  endfunction

  // Register map expressed arithmetically on signed sample values.
  function automatic logic [7:0] m_read(input logic [7:0] a);
    int s;
    int k;
    int ai;
    logic [7:0] r;
    r  = 8'h00;
    ai = int'(a);
    if (ai == 0) r = 8'hAD;
    else if (ai == 1) r = 8'h1D;
    else if (ai == 2) r = 8'hF2;
    else if (ai >= 8 && ai <= 10) begin
      s = to_signed12(m_snap[ai - 8]);
      r = 8'((s >>> 4) & 255);
    end else if (ai >= 14 && ai <= 19) begin
      k = (ai - 14) / 2;
      s = to_signed12(m_snap[k]);
      r = (ai % 2 == 1) ? 8'((s >>> 8) & 255) : 8'(s & 255);
    end else if (ai == 45) r = m_pwr;
    return r;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h2D) m_pwr = d;
    else if (a == 8'h1F && d == 8'h52) m_pwr = 8'h00;
  endtask

  task automatic strobe(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    m_hold[0] = int'(x);
    m_hold[1] = int'(y);
    m_hold[2] = int'(z);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'd0;
    for (int b = 0; b < nbits; b++) begin
      mosi = tx[7-b];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], miso};
      if (b == nbits - 1 && clr_zero_on_last) chk_miso_zero = 1'b0;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] addr, input int ndata,
                     input int part, input logic [31:0] wdata, output logic [31:0] rdata);
    logic [7:0] rx;
    int d0;
    bit is_rd;
    is_rd = (cmd == 8'h0B);
    chk_pwr = 1'b0;
    chk_miso_zero = 1'b1;
    clr_zero_on_last = 1'b0;
    for (int k = 0; k < 3; k++) m_snap[k] = m_hold[k];
    d0 = done_cnt;
    rdata = 32'd0;
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_xfer(cmd, 8, rx);
    clr_zero_on_last = is_rd;
    spi_xfer(addr, 8, rx);
    clr_zero_on_last = 1'b0;
    for (int i = 0; i < ndata; i++) begin
      spi_xfer(wdata[8*i +: 8], 8, rx);
      rdata[8*i +: 8] = rx;
      if (i == 0 && mid_en) strobe(12'(m_hold[0]), mid_y, 12'(m_hold[2]));
    end
    if (part > 0) spi_xfer(wdata[8*ndata +: 8], part, rx);
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    if (end_en) strobe(end_x, 12'(m_hold[1]), 12'(m_hold[2]));
    mid_en = 1'b0;
    end_en = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < ndata; i++) begin
      if (is_rd) check("read_byte", {24'd0, rdata[8*i +: 8]}, {24'd0, m_read(8'(int'(addr) + i))});
      else check("nonread_miso", {24'd0, rdata[8*i +: 8]}, 32'd0);
    end
    if (cmd == 8'h0A) for (int i = 0; i < ndata; i++) m_write(8'(int'(addr) + i), wdata[8*i +: 8]);
    check("txn_done_count", 32'(done_cnt - d0), 32'd1);
    chk_miso_zero = 1'b1;
    chk_pwr = 1'b1;
  endtask

  logic [7:0] alist [0:15];

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  rx;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wd;
    int d0;
    int sel;
    int nd;
    int pb;

    alist = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A, 8'h0E, 8'h0F,
              8'h10, 8'h11, 8'h12, 8'h13, 8'h1E, 8'h2C, 8'h2D, 8'hFE};
    for (int k = 0; k < 3; k++) begin
      m_hold[k] = 0;
      m_snap[k] = 0;
    end

    repeat (4) @(negedge clk);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_power_ctl", {24'd0, power_ctl}, 32'd0);
    check("reset_txn_done", {31'd0, txn_done}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_miso_zero = 1'b1;
    chk_pwr = 1'b1;

    txn(8'h0B, 8'h00, 3, 0, 32'd0, rd);
    check("id_ad", {24'd0, rd[7:0]}, 32'hAD);
    check("id_1d", {24'd0, rd[15:8]}, 32'h1D);
    check("id_f2", {24'd0, rd[23:16]}, 32'hF2);

    strobe(12'hF83, 12'h000, 12'h000);
    repeat (4) @(negedge clk);
    txn(8'h0B, 8'h0E, 2, 0, 32'd0, rd);
    check("x_low", {24'd0, rd[7:0]}, 32'h83);
    check("x_high", {24'd0, rd[15:8]}, 32'hFF);

    txn(8'h0A, 8'h2D, 1, 0, 32'h02, rd);
    check("pwr_write", {24'd0, power_ctl}, 32'h02);
    txn(8'h0A, 8'h1F, 1, 0, 32'h52, rd);
    check("soft_reset", {24'd0, power_ctl}, 32'h00);

    txn(8'h0B, 8'hFF, 2, 0, 32'd0, rd);
    check("wrap_ff", {24'd0, rd[7:0]}, 32'h00);
    check("wrap_00", {24'd0, rd[15:8]}, 32'hAD);

    txn(8'h0A, 8'h2D, 1, 0, 32'h07, rd);
    txn(8'h0A, 8'h2D, 0, 5, 32'hFF, rd);
    check("partial_write", {24'd0, power_ctl}, 32'h07);
    txn(8'h55, 8'h00, 2, 0, 32'd0, rd);
    check("bad_cmd_miso", {16'd0, rd[15:0]}, 32'h0);

    strobe(12'h000, 12'h7A5, 12'h000);
    repeat (4) @(negedge clk);
    mid_en = 1'b1;
    mid_y = 12'h123;
    txn(8'h0B, 8'h10, 2, 0, 32'd0, rd);
    check("snap_y_low", {24'd0, rd[7:0]}, 32'hA5);
    check("snap_y_high", {24'd0, rd[15:8]}, 32'h07);
    txn(8'h0B, 8'h10, 2, 0, 32'd0, rd);
    check("new_y_low", {24'd0, rd[7:0]}, 32'h23);
    check("new_y_high", {24'd0, rd[15:8]}, 32'h01);

    end_en = 1'b1;
    end_x = 12'h800;
    txn(8'h0B, 8'h00, 1, 0, 32'd0, rd);
    txn(8'h0B, 8'h0E, 2, 0, 32'd0, rd);
    check("end_x_low", {24'd0, rd[7:0]}, 32'h00);
    check("end_x_high", {24'd0, rd[15:8]}, 32'hF8);
    txn(8'h0B, 8'h08, 1, 0, 32'd0, rd);
    check("end_x_top", {24'd0, rd[7:0]}, 32'h80);

    txn(8'h0A, 8'h2D, 1, 0, 32'h11, rd);
    chk_pwr = 1'b0;
    chk_miso_zero = 1'b0;
    d0 = done_cnt;
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h2D, 8, rx);
    spi_xfer(8'hC3, 3, rx);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_power_ctl", {24'd0, power_ctl}, 32'h00);
    reset = 1'b0;
    m_pwr = 8'h00;
    for (int k = 0; k < 3; k++) m_hold[k] = 0;
    chk_miso_zero = 1'b1;
    spi_xfer(8'h44, 8, rx);
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_ignored", {24'd0, power_ctl}, 32'h00);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    chk_pwr = 1'b1;
    txn(8'h0A, 8'h2D, 1, 0, 32'h11, rd);
    check("post_reset_write", {24'd0, power_ctl}, 32'h11);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        strobe(12'($urandom), 12'($urandom), 12'($urandom));
        repeat (3) @(negedge clk);
      end
      sel = int'($urandom_range(9, 0));
      if (sel < 5) cmd = 8'h0B;
      else if (sel < 8) cmd = 8'h0A;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'($urandom);
      end
      if ($urandom_range(3, 0) == 0) addr = 8'($urandom);
      else addr = alist[$urandom_range(15, 0)];
      nd = int'($urandom_range(3, 1));
      pb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
      wd = $urandom;
      if ($urandom_range(1, 0) == 1) wd[15:8] = 8'h52;
      if ($urandom_range(3, 0) == 0) addr = 8'h1E;
      txn(cmd, addr, nd, pb, wd, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
